// File: rtl/sa_job_scheduler.sv
// Descriptor FIFO plus dispatch FSM for the systolic tile engine: runs one job at a time with its
// configuration held steady, and reports each job's completion status through cmp_* and irq.
module sa_job_scheduler #(
    parameter int DEPTH  = 4,
    parameter int TO_CYC = 65536
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [7:0]             job_k,
    input  logic                   job_mode,
    input  logic [7:0]             job_rows,
    input  logic [7:0]             job_cols,
    input  logic [3:0]             job_tag,
    output logic                   sa_start_all,
    output logic [7:0]             sa_k_param,
    output logic                   sa_out_mode,
    output logic [7:0]             sa_row_shape,
    output logic [7:0]             sa_col_shape,
    input  logic                   sa_done_all,
    input  logic                   abort,
    output logic                   cmp_valid,
    output logic [3:0]             cmp_tag,
    output logic [1:0]             cmp_status,
    output logic                   irq,
    input  logic                   irq_clr,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            jobs_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TO_CYC);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TO_CYC - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_RUN, ST_DONE, ST_HALT} state_t;
    typedef enum logic [1:0] {
        CMP_OK        = 2'b00,
        CMP_BAD_SHAPE = 2'b01,
        CMP_TIMEOUT   = 2'b10,
        CMP_ABORT     = 2'b11
    } status_t;
    typedef struct packed {
        logic [7:0] k;
        logic       mode;
        logic [7:0] rows;
        logic [7:0] cols;
        logic [3:0] tag;
    } job_t;

    state_t          state;
    job_t            mem [DEPTH];
    job_t            job_in;
    job_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [WW-1:0]   wdog;
    logic [3:0]      cur_tag;
    logic            push;
    logic            pop;
    logic            load_en;
    logic            bad_shape;

    assign job_in    = '{job_k, job_mode, job_rows, job_cols, job_tag};
    assign head      = mem[rd_ptr];
    assign job_ready = (fifo_count != CW'(DEPTH));
    assign busy      = (state != ST_IDLE);
    // Abort flushes the queue, so a push landing in the same cycle is dropped.
    assign push      = job_valid && job_ready && !abort;
    assign pop       = (state == ST_LOAD) && !abort;
    assign bad_shape = (sa_row_shape == '0) || (sa_col_shape == '0) || (sa_k_param == '0);

    // The head is captured on the edge that enters LOAD and popped on the edge that leaves it,
    // so the engine sees its configuration for a full cycle before the start pulse.
    assign load_en = !abort && (fifo_count != '0) &&
                     ((state == ST_IDLE) || (state == ST_DONE && cmp_status != CMP_TIMEOUT));

    // NOTE: descriptor storage has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= job_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_k_param   <= '0;
            sa_out_mode  <= 1'b0;
            sa_row_shape <= '0;
            sa_col_shape <= '0;
            cur_tag      <= '0;
        end else if (load_en) begin
            sa_k_param   <= head.k;
            sa_out_mode  <= head.mode;
            sa_row_shape <= head.rows;
            sa_col_shape <= head.cols;
            cur_tag      <= head.tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sa_start_all <= 1'b0;
            cmp_valid    <= 1'b0;
            cmp_tag      <= '0;
            cmp_status   <= CMP_OK;
            irq          <= 1'b0;
            wdog         <= '0;
            jobs_done    <= '0;
        end else begin
            sa_start_all <= 1'b0;
            cmp_valid    <= 1'b0;
            // irq follows cmp_valid by a cycle, so a clear during the completion cycle loses.
            irq          <= cmp_valid || (irq && !irq_clr);
            if (abort) begin
                state <= ST_IDLE;
                if (state == ST_START || state == ST_RUN) begin
                    cmp_valid  <= 1'b1;
                    cmp_tag    <= cur_tag;
                    cmp_status <= CMP_ABORT;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (load_en) state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (bad_shape) begin
                            state      <= ST_DONE;
                            cmp_valid  <= 1'b1;
                            cmp_tag    <= cur_tag;
                            cmp_status <= CMP_BAD_SHAPE;
                        end else begin
                            state        <= ST_START;
                            sa_start_all <= 1'b1;
                        end
                    end
                    ST_START: begin
                        state <= ST_RUN;
                        wdog  <= '0;
                    end
                    ST_RUN: begin
                        if (sa_done_all) begin
                            state      <= ST_DONE;
                            cmp_valid  <= 1'b1;
                            cmp_tag    <= cur_tag;
                            cmp_status <= CMP_OK;
                            if (jobs_done != 16'hFFFF) jobs_done <= jobs_done + 16'd1;
                        end else if (wdog == WDOG_LAST) begin
                            state      <= ST_DONE;
                            cmp_valid  <= 1'b1;
                            cmp_tag    <= cur_tag;
                            cmp_status <= CMP_TIMEOUT;
                        end else begin
                            wdog <= wdog + WW'(1);
                        end
                    end
                    ST_DONE: begin
                        if (cmp_status == CMP_TIMEOUT) state <= ST_HALT;
                        else if (load_en)              state <= ST_LOAD;
                        else                           state <= ST_IDLE;
                    end
                    ST_HALT: state <= ST_HALT;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sa_job_scheduler.sv
// Bench for sa_job_scheduler: cycle vector table, directed multi-cycle corner cases, then random
// traffic checked against a queue-based reference model.
module tb_sa_job_scheduler;
    localparam int DEPTH = 4;
    localparam int TO    = 48;

    typedef struct packed {
        logic [7:0] k;
        logic       mode;
        logic [7:0] rows;
        logic [7:0] cols;
        logic [3:0] tag;
    } job_t;

    typedef struct packed {
        logic       v;
        logic [7:0] k;
        logic [7:0] rows;
        logic [7:0] cols;
        logic [3:0] tag;
        logic       done;
        logic       ab;
        logic       clr;
        logic       e_start;
        logic       e_busy;
        logic       e_cmpv;
        logic [1:0] e_st;
        logic [3:0] e_tag;
        logic [2:0] e_cnt;
        logic       e_irq;
        logic [15:0] e_jd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [7:0]  job_k;
    logic        job_mode;
    logic [7:0]  job_rows;
    logic [7:0]  job_cols;
    logic [3:0]  job_tag;
    logic        sa_start_all;
    logic [7:0]  sa_k_param;
    logic        sa_out_mode;
    logic [7:0]  sa_row_shape;
    logic [7:0]  sa_col_shape;
    logic        sa_done_all;
    logic        abort;
    logic        cmp_valid;
    logic [3:0]  cmp_tag;
    logic [1:0]  cmp_status;
    logic        irq;
    logic        irq_clr;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [15:0] jobs_done;

    int n_cmp = 0;
    int n_bad = 0;

    sa_job_scheduler #(.DEPTH(DEPTH), .TO_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_k(job_k), .job_mode(job_mode),
        .job_rows(job_rows), .job_cols(job_cols), .job_tag(job_tag),
        .sa_start_all(sa_start_all), .sa_k_param(sa_k_param), .sa_out_mode(sa_out_mode),
        .sa_row_shape(sa_row_shape), .sa_col_shape(sa_col_shape), .sa_done_all(sa_done_all),
        .abort(abort), .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_status(cmp_status),
        .irq(irq), .irq_clr(irq_clr), .busy(busy), .fifo_count(fifo_count), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        job_valid   = 1'b0;
        sa_done_all = 1'b0;
        abort       = 1'b0;
        irq_clr     = 1'b0;
    endtask

    task automatic set_job(input int k, input int mode, input int rows, input int cols, input int tag);
        job_valid = 1'b1;
        job_k     = k[7:0];
        job_mode  = mode[0];
        job_rows  = rows[7:0];
        job_cols  = cols[7:0];
        job_tag   = tag[3:0];
    endtask

    task automatic push(input int k, input int mode, input int rows, input int cols, input int tag);
        set_job(k, mode, rows, cols, tag);
        tick();
        job_valid = 1'b0;
    endtask

    // Returns the number of cycles after the push edge at which sa_start_all is seen, -1 if never.
    task automatic wait_start(output int lat);
        lat = -1;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            tick();
            if (sa_start_all) lat = c;
        end
    endtask

    function automatic vec_t mk(input int v, input int k, input int rows, input int cols,
                                input int tag, input int done, input int ab, input int clr,
                                input int es, input int eb, input int ec, input int est,
                                input int etag, input int ecnt, input int eirq, input int ejd);
        vec_t r;
        r.v = v[0];     r.k = k[7:0];       r.rows = rows[7:0];   r.cols = cols[7:0];
        r.tag = tag[3:0]; r.done = done[0]; r.ab = ab[0];         r.clr = clr[0];
        r.e_start = es[0]; r.e_busy = eb[0]; r.e_cmpv = ec[0];    r.e_st = est[1:0];
        r.e_tag = etag[3:0]; r.e_cnt = ecnt[2:0]; r.e_irq = eirq[0]; r.e_jd = ejd[15:0];
        return r;
    endfunction

    // Reference model: a job queue plus the phase of the job currently owned by the engine.
    localparam int P_IDLE = 0, P_PREP = 1, P_FIRE = 2, P_WAIT = 3, P_REPORT = 4, P_STUCK = 5;
    job_t        mq[$];
    job_t        m_cfg;
    int          m_ph;
    int          m_run;
    logic        m_start, m_cmpv, m_irq;
    logic [3:0]  m_ctag;
    logic [1:0]  m_cst;
    logic [15:0] m_jd;

    task automatic model_reset();
        mq.delete();
        m_cfg = '0; m_ph = P_IDLE; m_run = 0;
        m_start = 1'b0; m_cmpv = 1'b0; m_irq = 1'b0;
        m_ctag = '0; m_cst = '0; m_jd = '0;
    endtask

    task automatic model_report(input logic [1:0] st);
        m_cmpv = 1'b1;
        m_ctag = m_cfg.tag;
        m_cst  = st;
    endtask

    task automatic model_step(input logic v, input job_t j, input logic d, input logic ab,
                              input logic clr);
        int  held      = mq.size();
        bit  room      = held < DEPTH;
        bool_irq: m_irq = m_cmpv || (m_irq && !clr);
        m_start = 1'b0;
        m_cmpv  = 1'b0;
        if (ab) begin
            if (m_ph == P_FIRE || m_ph == P_WAIT) model_report(2'b11);
            mq.delete();
            m_ph = P_IDLE;
        end else begin
            case (m_ph)
                P_IDLE: if (held > 0) begin m_ph = P_PREP; m_cfg = mq[0]; end
                P_PREP: begin
                    void'(mq.pop_front());
                    if (m_cfg.rows == 0 || m_cfg.cols == 0 || m_cfg.k == 0) begin
                        model_report(2'b01);
                        m_ph = P_REPORT;
                    end else begin
                        m_start = 1'b1;
                        m_ph = P_FIRE;
                    end
                end
                P_FIRE: begin m_ph = P_WAIT; m_run = 0; end
                P_WAIT: begin
                    if (d) begin
                        model_report(2'b00);
                        if (m_jd != 16'hFFFF) m_jd = m_jd + 16'd1;
                        m_ph = P_REPORT;
                    end else if (m_run == TO - 1) begin
                        model_report(2'b10);
                        m_ph = P_REPORT;
                    end else begin
                        m_run++;
                    end
                end
                P_REPORT: begin
                    if (m_cst == 2'b10)  m_ph = P_STUCK;
                    else if (held > 0) begin m_ph = P_PREP; m_cfg = mq[0]; end
                    else               m_ph = P_IDLE;
                end
                default: m_ph = m_ph;
            endcase
            if (v && room) mq.push_back(j);
        end
    endtask

    vec_t        tbl[12];
    logic [3:0]  tags[$];
    int          lat, seen, pulses, acc, dly, exp_jd;
    bit          ok;
    logic [63:0] act_v, exp_v;

    initial begin
        quiet_inputs();
        job_k = '0; job_mode = 1'b0; job_rows = '0; job_cols = '0; job_tag = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset job_ready", job_ready, 1);
        check("reset outputs", {busy, fifo_count, sa_start_all, cmp_valid, irq, jobs_done}, 0);
        check("reset config", {sa_k_param, sa_out_mode, sa_row_shape, sa_col_shape}, 0);
        #2 rst_n = 1'b1;
        tick();

        //           v k rows cols tag dn ab clr | st bsy cv sts tag cnt irq jd
        tbl[0]  = mk(1, 4, 0, 3, 2,   0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0,   0, 0, 0,   0, 1, 0, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,   0, 0, 0,   0, 1, 1, 1, 2, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(1, 8, 2, 3, 5,   0, 0, 0,   0, 0, 0, 0, 0, 1, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,   0, 0, 0,   0, 1, 0, 0, 0, 1, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0,   0, 0, 0,   1, 1, 0, 0, 0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0,   0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0,   1, 0, 1,   0, 1, 1, 0, 5, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 1);
        tbl[10] = mk(0, 0, 0, 0, 0,   1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 12; i++) begin
            job_valid = tbl[i].v; job_k = tbl[i].k; job_mode = 1'b0;
            job_rows = tbl[i].rows; job_cols = tbl[i].cols; job_tag = tbl[i].tag;
            sa_done_all = tbl[i].done; abort = tbl[i].ab; irq_clr = tbl[i].clr;
            tick();
            check($sformatf("vec%0d start", i), sa_start_all, tbl[i].e_start);
            check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
            check($sformatf("vec%0d cmp_valid", i), cmp_valid, tbl[i].e_cmpv);
            check($sformatf("vec%0d count", i), fifo_count, tbl[i].e_cnt);
            check($sformatf("vec%0d irq", i), irq, tbl[i].e_irq);
            check($sformatf("vec%0d jobs_done", i), jobs_done, tbl[i].e_jd);
            if (tbl[i].e_cmpv) check($sformatf("vec%0d cmp tag/status", i),
                                     {cmp_tag, cmp_status}, {tbl[i].e_tag, tbl[i].e_st});
        end
        quiet_inputs();
        exp_jd = 1;

        // Single job, 40 cycles in RUN, config stable throughout.
        push(8, 0, 2, 3, 5);
        check("t1 count", fifo_count, 1);
        tick();
        check("t1 config at load", {sa_k_param, sa_out_mode, sa_row_shape, sa_col_shape},
              {8'd8, 1'b0, 8'd2, 8'd3});
        check("t1 no early start", sa_start_all, 0);
        tick();
        check("t1 start after 2", sa_start_all, 1);
        ok = 1'b1; pulses = 0;
        repeat (40) begin
            tick();
            if ({sa_k_param, sa_out_mode, sa_row_shape, sa_col_shape} !== {8'd8, 1'b0, 8'd2, 8'd3}
                || !busy || cmp_valid) ok = 1'b0;
            if (sa_start_all) pulses++;
        end
        check("t1 config stable in run", ok, 1);
        check("t1 single start pulse", pulses, 0);
        sa_done_all = 1'b1;
        tick();
        sa_done_all = 1'b0;
        exp_jd++;
        check("t1 cmp", {cmp_valid, cmp_tag, cmp_status}, {1'b1, 4'd5, 2'b00});
        check("t1 jobs_done", jobs_done, exp_jd);
        tick();
        check("t1 irq", {irq, busy, cmp_valid}, {1'b1, 1'b0, 1'b0});

        // FIFO fills to DEPTH while a job runs; the fifth push waits for a pop.
        push(10, 1, 4, 4, 1);
        wait_start(lat);
        check("t2 start latency", lat, 2);
        tick();
        for (int t = 2; t <= 5; t++) push(t, 0, 1, 1, t);
        check("t2 full count", fifo_count, 4);
        check("t2 not ready", job_ready, 0);
        set_job(6, 0, 1, 1, 6);
        tick();
        tick();
        check("t2 fifth held", {fifo_count, job_ready}, {3'd4, 1'b0});
        tags.delete(); acc = -1; dly = -1;
        sa_done_all = 1'b1;
        for (int c = 0; c < 300 && tags.size() < 6; c++) begin
            ok = job_valid && job_ready;
            tick();
            sa_done_all = 1'b0;
            if (ok) begin job_valid = 1'b0; acc = c; end
            if (cmp_valid) tags.push_back(cmp_tag);
            if (sa_start_all) dly = 3;
            else if (dly > 0) begin
                dly--;
                if (dly == 0) sa_done_all = 1'b1;
            end
        end
        quiet_inputs();
        check("t2 fifth accepted", acc >= 0, 1);
        check("t2 completions", tags.size(), 6);
        if (tags.size() == 6)
            for (int i = 0; i < 6; i++) check($sformatf("t2 order %0d", i), tags[i], i + 1);
        exp_jd += 6;
        tick();
        check("t2 jobs_done", jobs_done, exp_jd);

        // Watchdog expiry, HALT holds the queue, abort recovers without a completion.
        push(3, 0, 1, 1, 7);
        wait_start(lat);
        check("t4 start latency", lat, 2);
        set_job(4, 0, 1, 1, 8);
        tick();
        job_valid = 1'b0;
        seen = -1;
        for (int s = 2; s <= TO + 8 && seen < 0; s++) begin
            tick();
            if (cmp_valid) seen = s;
        end
        check("t4 timeout cycle", seen, TO + 1);
        check("t4 timeout cmp", {cmp_tag, cmp_status}, {4'd7, 2'b10});
        tick();
        sa_done_all = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            tick();
            sa_done_all = 1'b0;
            if (sa_start_all || cmp_valid || !busy || fifo_count != 3'd1) ok = 1'b0;
        end
        check("t4 halt holds", ok, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4 abort from halt", {busy, fifo_count, cmp_valid}, 0);
        ok = 1'b1;
        repeat (4) begin
            tick();
            if (sa_start_all || busy || cmp_valid) ok = 1'b0;
        end
        check("t4 idle after abort", ok, 1);
        check("t4 jobs_done", jobs_done, exp_jd);

        // Abort during RUN with two queued; a same-cycle push is dropped.
        push(5, 0, 2, 2, 9);
        wait_start(lat);
        check("t5 start latency", lat, 2);
        tick();
        push(5, 0, 2, 2, 10);
        push(5, 0, 2, 2, 11);
        check("t5 queued", fifo_count, 2);
        set_job(5, 0, 2, 2, 12);
        abort = 1'b1;
        tick();
        quiet_inputs();
        check("t5 abort cmp", {cmp_valid, cmp_tag, cmp_status}, {1'b1, 4'd9, 2'b11});
        check("t5 flushed", {fifo_count, busy}, 0);
        tick();
        check("t5 quiet", {cmp_valid, busy, fifo_count, sa_start_all}, 0);

        // done_all on the last watchdog cycle wins; irq_clr during the completion loses.
        push(7, 1, 3, 3, 12);
        wait_start(lat);
        check("t6 start latency", lat, 2);
        repeat (TO) tick();
        check("t6 still running", {busy, cmp_valid}, {1'b1, 1'b0});
        sa_done_all = 1'b1;
        tick();
        sa_done_all = 1'b0;
        irq_clr = 1'b1;
        exp_jd++;
        check("t6 done beats timeout", {cmp_valid, cmp_tag, cmp_status}, {1'b1, 4'd12, 2'b00});
        tick();
        irq_clr = 1'b0;
        check("t6 irq set wins", irq, 1);
        check("t6 jobs_done", jobs_done, exp_jd);

        // Asynchronous reset mid-job.
        push(9, 0, 2, 2, 3);
        wait_start(lat);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", {busy, fifo_count, sa_start_all, cmp_valid, irq, jobs_done}, 0);
        check("async reset config", {sa_k_param, sa_out_mode, sa_row_shape, sa_col_shape}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("no completion after reset", {cmp_valid, busy}, 0);

        // Random traffic against the reference model.
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            job_t j;
            int   pd = (c < 2000) ? 15 : 3;
            job_valid   = ($urandom_range(0, 99) < 40);
            j.k         = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            j.mode      = 1'($urandom_range(0, 1));
            j.rows      = ($urandom_range(0, 14) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            j.cols      = ($urandom_range(0, 14) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            j.tag       = 4'($urandom_range(0, 15));
            job_k = j.k; job_mode = j.mode; job_rows = j.rows; job_cols = j.cols; job_tag = j.tag;
            sa_done_all = ($urandom_range(0, 99) < pd);
            abort       = ($urandom_range(0, 99) < 2);
            irq_clr     = ($urandom_range(0, 99) < 10);
            model_step(job_valid, j, sa_done_all, abort, irq_clr);
            tick();
            act_v = {9'd0, job_ready, fifo_count, busy, sa_start_all, cmp_valid,
                     cmp_valid ? {cmp_tag, cmp_status} : 6'd0, irq, jobs_done,
                     sa_k_param, sa_out_mode, sa_row_shape, sa_col_shape};
            exp_v = {9'd0, mq.size() < DEPTH, 3'(mq.size()), m_ph != P_IDLE, m_start, m_cmpv,
                     m_cmpv ? {m_ctag, m_cst} : 6'd0, m_irq, m_jd,
                     m_cfg.k, m_cfg.mode, m_cfg.rows, m_cfg.cols};
            check($sformatf("rand cycle %0d", c), act_v, exp_v);
        end
        quiet_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
